// File: rtl/regfile_wb_8x.sv
// regfile_wb_8x: 8-entry register file with write-through bypass and per-register pending-write scoreboard
module regfile_wb_8x #(
  parameter int DATA_W  = 16,
  parameter int PEND_W  = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [2:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              iss_valid,
  input  logic              iss_wr,
  input  logic [2:0]        iss_dest,
  output logic [7:0]        busy,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              pend_full,
  output logic              err_sel,
  output logic              err_uflow
);
  localparam logic [PEND_W-1:0] MAX = '1;
  localparam logic [7:0] KEEP = (ZERO_R0 != 0) ? 8'hFE : 8'hFF;
  logic [DATA_W-1:0] regs [8];
  logic [PEND_W-1:0] cnt [8];
  logic one_hot;
  logic [7:0] wmask, inc, dec;
  assign one_hot   = (wr_sel != 8'h00) && ((wr_sel & (wr_sel - 8'h01)) == 8'h00);
  assign wmask     = (wr_en && one_hot) ? (wr_sel & KEEP) : 8'h00;
  assign pend_full = cnt[iss_dest] == MAX;
  assign rd_data_a = wmask[rd_addr_a] ? wr_data : regs[rd_addr_a];
  assign rd_data_b = wmask[rd_addr_b] ? wr_data : regs[rd_addr_b];
  assign hazard_a  = cnt[rd_addr_a] != PEND_W'(dec[rd_addr_a]);
  assign hazard_b  = cnt[rd_addr_b] != PEND_W'(dec[rd_addr_b]);
  // per-register issue/retire strobes; R0 never counts when it is hardwired to zero
  always_comb begin
    inc  = 8'h00;
    dec  = 8'h00;
    busy = 8'h00;
    for (int i = 0; i < 8; i++) begin
      busy[i] = cnt[i] != '0;
      inc[i]  = iss_valid & iss_wr & (iss_dest == 3'(i)) & ~pend_full & KEEP[i];
      dec[i]  = wmask[i] & busy[i];
    end
  end
  // register array, pending counters and sticky error flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      err_sel   <= 1'b0;
      err_uflow <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wmask[i]) regs[i] <= wr_data;
        if (inc[i] && !dec[i]) cnt[i] <= cnt[i] + 1'b1;
        else if (dec[i] && !inc[i]) cnt[i] <= cnt[i] - 1'b1;
      end
      err_sel   <= err_sel | (wr_en & ~one_hot);
      err_uflow <= err_uflow | (|(wmask & ~busy));
    end
  end
endmodule

// File: tb/tb_regfile_wb_8x.sv
// tb_regfile_wb_8x: directed scoreboard bench for regfile_wb_8x
module tb_regfile_wb_8x;
  logic clk = 0, reset_n = 1, wr_en = 0, iss_valid = 0, iss_wr = 0;
  logic [7:0] wr_sel = 0;
  logic [15:0] wr_data = 0;
  logic [2:0] rd_addr_a = 0, rd_addr_b = 0, iss_dest = 0;
  logic [15:0] rd_data_a, rd_data_b;
  logic [7:0] busy;
  logic hazard_a, hazard_b, pend_full, err_sel, err_uflow;
  int tests = 0, fails = 0;
  typedef struct {string tag; logic [31:0] exp;} exp_t;
  exp_t q[$];

  regfile_wb_8x dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_dest(iss_dest), .busy(busy),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .pend_full(pend_full),
    .err_sel(err_sel), .err_uflow(err_uflow)
  );

  always #5 clk = ~clk;

  task automatic push(string t, logic [31:0] v);
    q.push_back('{t, v});
  endtask

  task automatic pop(logic [31:0] obs);
    exp_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: got %0h with nothing expected", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    iss_wr = 1;
    #2 reset_n = 0;
    tick();
    push("busy_in_reset", 0); #1 pop(busy);
    reset_n = 1;
    tick();
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      rd_addr_b = 3'(7 - a);
      push("rst_rd_a", 0); push("rst_rd_b", 0);
      #1 pop(rd_data_a); pop(rd_data_b);
    end
    push("rst_busy", 0); push("rst_err_sel", 0); push("rst_err_uflow", 0);
    push("rst_hazard_a", 0); push("rst_pend_full", 0);
    pop(busy); pop(err_sel); pop(err_uflow); pop(hazard_a); pop(pend_full);
    iss_valid = 1; iss_dest = 3; rd_addr_a = 3;
    tick();
    iss_valid = 0;
    for (int k = 0; k < 3; k++) begin
      push("haz3_pending", 1); push("busy3", 8'h08);
      #1 pop(hazard_a); pop(busy);
      tick();
    end
    wr_en = 1; wr_sel = 8'h08; wr_data = 16'hBEEF;
    push("bypass_r3", 16'hBEEF); push("haz3_cleared", 0);
    #1 pop(rd_data_a); pop(hazard_a);
    tick();
    wr_en = 0;
    push("busy_after_wb3", 0); push("r3_stored", 16'hBEEF);
    #1 pop(busy); pop(rd_data_a);
    iss_valid = 1; iss_dest = 5; rd_addr_b = 5;
    for (int k = 0; k < 3; k++) begin
      push("pend5_not_full", 0);
      #1 pop(pend_full);
      tick();
    end
    push("pend5_full", 1); push("busy5", 8'h20);
    #1 pop(pend_full); pop(busy);
    tick();
    iss_valid = 0;
    wr_en = 1; wr_sel = 8'h20; wr_data = 16'h1234;
    push("bypass_r5", 16'h1234); push("haz5_still", 1);
    #1 pop(rd_data_b); pop(hazard_b);
    tick();
    wr_en = 0;
    push("pend5_after_dec", 0);
    #1 pop(pend_full);
    wr_en = 1; wr_data = 16'h5555; iss_valid = 1;
    tick();
    wr_en = 0;
    push("pend5_same_cycle", 0);
    #1 pop(pend_full);
    tick();
    iss_valid = 0;
    push("pend5_refilled", 1);
    #1 pop(pend_full);
    for (int k = 0; k < 3; k++) begin
      wr_en = 1; wr_data = 16'(k);
      tick();
      wr_en = 0;
      push("busy5_drain", (k < 2) ? 8'h20 : 8'h00);
      #1 pop(busy);
    end
    push("r5_last", 16'h0002); push("no_uflow_yet", 0);
    pop(rd_data_b); pop(err_uflow);
    rd_addr_a = 2; rd_addr_b = 3;
    wr_en = 1; wr_sel = 8'h0C; wr_data = 16'hFFFF;
    push("multihot_no_bypass_a", 0); push("multihot_no_bypass_b", 16'hBEEF);
    #1 pop(rd_data_a); pop(rd_data_b);
    tick();
    wr_en = 0;
    push("err_sel_set", 1); push("r2_unchanged", 0); push("r3_unchanged", 16'hBEEF);
    push("multihot_busy", 0);
    #1 pop(err_sel); pop(rd_data_a); pop(rd_data_b); pop(busy);
    tick();
    push("err_sel_sticky", 1);
    #1 pop(err_sel);
    rd_addr_a = 0; wr_en = 1; wr_sel = 8'h01; wr_data = 16'hAAAA;
    push("r0_bypass_zero", 0);
    #1 pop(rd_data_a);
    tick();
    wr_en = 0;
    push("r0_reads_zero", 0);
    #1 pop(rd_data_a);
    rd_addr_b = 6; wr_en = 1; wr_sel = 8'h40; wr_data = 16'h6666;
    push("bypass_r6", 16'h6666); push("haz6_none", 0);
    #1 pop(rd_data_b); pop(hazard_b);
    tick();
    wr_en = 0;
    push("r6_stored", 16'h6666); push("err_uflow_set", 1); push("busy_uflow", 0);
    #1 pop(rd_data_b); pop(err_uflow); pop(busy);
    iss_valid = 1; iss_dest = 1;
    tick();
    iss_dest = 2;
    tick();
    iss_valid = 0;
    rd_addr_a = 3;
    push("busy_before_reset", 8'h06);
    #1 pop(busy);
    #1 reset_n = 0;
    #1;
    push("async_busy", 0); push("async_r3", 0); push("async_r6", 0);
    push("async_err_sel", 0); push("async_err_uflow", 0);
    pop(busy); pop(rd_data_a); pop(rd_data_b); pop(err_sel); pop(err_uflow);
    reset_n = 1;
    tick();
    push("busy_after_release", 0);
    #1 pop(busy);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
